player_motion: RTL and testbench
================================

// Module: player_motion
// PURPOSE
// - Upstream of the player sprite renderer: turns button_1/button_2 into a 9-bit pixel position (pos_x, pos_y) on a 32 px maze grid.
// - Advances one pixel per step pulse; starts a move only from a cell-aligned position and refuses moves through walls or the border.
// - The top level issues step when the player renderer is idle; pos_x/pos_y drive the renderer x/y (plus the draw offset).
// PARAMETERS
// - GRID_W     10  cells per row (x)
// - GRID_H     15  cells per column (y)
// - CELL_BITS  5   log2 of cell size in px (32 px)
// PORTS
// - clk           in   1    system clock
// - rst           in   1    reset, asynchronous, active-low
// - button_1      in   1    direction MSB (asynchronous to clk)
// - button_2      in   1    direction LSB (asynchronous to clk)
// - step          in   1    1-cycle pulse: advance one pixel
// - h_walls       in   GRID_W*(GRID_H+1)      bit r*GRID_W+c = wall on top edge of cell (c,r); r=GRID_H is the bottom border
// - v_walls       in   (GRID_W+1)*GRID_H      bit r*(GRID_W+1)+c = wall on left edge of cell (c,r); c=GRID_W is the right border
// - pos_x         out  9    player x in px
// - pos_y         out  9    player y in px
// - cell_x        out  4    pos_x[8:5], combinational
// - cell_y        out  4    pos_y[8:5], combinational
// - moving        out  1    1 while between cells
// - blocked       out  1    last move attempt was refused
// - cell_entered  out  1    1-cycle pulse when a move completes
// BEHAVIOUR
// - Reset: pos_x=pos_y=0, moving=0, blocked=0, cell_entered=0, dir=0, state=ALIGNED, sync flops=0.
// - Buttons pass through a 2-flop synchroniser; dir={b1_s,b2_s}: 0=+x, 1=+y, 2=-x, 3=-y.
// - FSM ALIGNED (pos_x[4:0]=0 and pos_y[4:0]=0):
//   - on step: latch dir. Target edge: +x v_walls[cy*(GRID_W+1)+cx+1]; -x v_walls[cy*(GRID_W+1)+cx]; +y h_walls[(cy+1)*GRID_W+cx]; -y h_walls[cy*GRID_W+cx].
//   - Border is always blocking regardless of wall bits (cx=GRID_W-1 for +x, cx=0 for -x, cy=GRID_H-1 for +y, cy=0 for -y).
//   - Free: pos +/-1 on that axis, moving=1, blocked=0, go MOVE. Blocked: pos unchanged, blocked=1, stay in ALIGNED.
// - MOVE: each step moves pos +/-1 along the latched dir; buttons are ignored.
//   - When the update makes the moving axis [4:0]=0: moving=0, cell_entered=1 for the next cycle only, go ALIGNED.
// - Latency: pos/moving/blocked/cell_entered update on the clk edge that samples step=1; step=0 holds all state.
// - One cell = exactly 32 accepted steps; back-to-back step every cycle is supported.
// - All arithmetic is 9-bit unsigned; underflow and overflow cannot occur (border rule).
// - Wall inputs are sampled only in ALIGNED on step; changes during MOVE have no effect.
// - Async reset mid-move returns to (0,0) immediately, no clock needed.
// CONFIGURATION
// - PLAYER_REVERSE_EN defined: in MOVE, a step whose synced dir is opposite to the latched dir (0<->2, 1<->3) latches the new dir and moves 1 px back.
//   - No wall check is made; the player is returning toward a cell already left.
//   - Alignment on return completes the move as above.
// - PLAYER_REVERSE_EN undefined: buttons are fully ignored in MOVE.
// TESTING
// - Reset, walls=0, buttons=00, 32 steps -> pos_x=32, pos_y=0, cell_entered high exactly 1 cycle after the 32nd step, moving=0.
// - At (0,0), buttons=10, step -> pos unchanged, blocked=1; buttons=01, step -> pos_y=1, blocked=0, moving=1.
// - v_walls bit 1 set, at (0,0), buttons=00, step -> pos_x=0, blocked=1, moving=0.
// - Buttons=00, 10 steps, then buttons=01 -> x reaches 32 after 22 more steps, y unchanged; next step -> pos_y=1.
// - pos_x=17 mid-move, assert rst between clk edges -> pos_x=0, moving=0 with no clk edge.
// - pos_x=10 moving +x, buttons=10, step -> pos_x=9 with PLAYER_REVERSE_EN, pos_x=11 without.

Source files
------------

// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
//   Converts the two direction buttons into a pixel position on a 32 px maze
//   grid. A move starts only from a cell-aligned position, checks the wall or
//   border on the edge being crossed, and then advances one pixel per step
//   pulse until the next cell is reached.
//
// Optional feature (compile-time macro PLAYER_REVERSE_EN):
//   defined   - while between cells, a step with the opposite direction
//               reverses the move (no wall check; the player heads back
//               toward the cell it just left).
//   undefined - buttons are ignored while between cells.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset
//   button_1/2    direction {msb,lsb}, asynchronous to clk
//   step          one-cycle pulse: advance one pixel
//   h_walls       top edge of cell (c,r) at bit r*GRID_W+c; row GRID_H = bottom border
//   v_walls       left edge of cell (c,r) at bit r*(GRID_W+1)+c; col GRID_W = right border
//   pos_x/pos_y   player position in px
//   cell_x/cell_y cell coordinates (upper position bits)
//   moving        high while between cells
//   blocked       last move attempt was refused
//   cell_entered  one-cycle pulse after a move completes
// -----------------------------------------------------------------------------
module player_motion #(
  parameter int GRID_W    = 10,
  parameter int GRID_H    = 15,
  parameter int CELL_BITS = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             button_1,
  input  logic                             button_2,
  input  logic                             step,
  input  logic [GRID_W*(GRID_H+1)-1:0]     h_walls,
  input  logic [(GRID_W+1)*GRID_H-1:0]     v_walls,
  output logic [8:0]                       pos_x,
  output logic [8:0]                       pos_y,
  output logic [8-CELL_BITS:0]             cell_x,
  output logic [8-CELL_BITS:0]             cell_y,
  output logic                             moving,
  output logic                             blocked,
  output logic                             cell_entered
);

  localparam int HW_N  = GRID_W * (GRID_H + 1);
  localparam int VW_N  = (GRID_W + 1) * GRID_H;
  localparam int HW_IW = $clog2(HW_N);
  localparam int VW_IW = $clog2(VW_N);

  // direction encoding: 0=+x 1=+y 2=-x 3=-y; bit 0 selects the y axis,
  // bit 1 selects the negative direction, so dir^2 is the opposite one
  typedef enum logic {ALIGNED = 1'b0, MOVE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        b1_q, b1_s, b2_q, b2_s;
  logic [1:0]  dir_s, dir, dir_nxt;
  logic [8:0]  pos_x_nxt, pos_y_nxt;
  logic        blocked_nxt, entered_nxt;

  // button synchronisers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b1_q <= 1'b0; b1_s <= 1'b0;
      b2_q <= 1'b0; b2_s <= 1'b0;
    end else begin
      b1_q <= button_1; b1_s <= b1_q;
      b2_q <= button_2; b2_s <= b2_q;
    end
  end

  assign dir_s  = {b1_s, b2_s};
  assign cell_x = pos_x[8:CELL_BITS];
  assign cell_y = pos_y[8:CELL_BITS];
  assign moving = (state == MOVE);

  // ---------------------------------------------------------------------------
  // Wall lookup for the edge the synced direction would cross. Only meaningful
  // while aligned; the border test comes first so the indices never matter
  // there.
  // ---------------------------------------------------------------------------
  int               cxi, cyi;
  logic [VW_IW-1:0] v_idx_l, v_idx_r;
  logic [HW_IW-1:0] h_idx_u, h_idx_d;
  logic             wall_hit;

  always_comb begin
    cxi     = int'(cell_x);
    cyi     = int'(cell_y);
    v_idx_l = VW_IW'(cyi * (GRID_W + 1) + cxi);
    v_idx_r = VW_IW'(cyi * (GRID_W + 1) + cxi + 1);
    h_idx_u = HW_IW'(cyi * GRID_W + cxi);
    h_idx_d = HW_IW'((cyi + 1) * GRID_W + cxi);
    wall_hit = 1'b0;
    case (dir_s)
      2'd0:    wall_hit = (cxi == GRID_W - 1) || v_walls[v_idx_r];
      2'd1:    wall_hit = (cyi == GRID_H - 1) || h_walls[h_idx_d];
      2'd2:    wall_hit = (cxi == 0)          || v_walls[v_idx_l];
      default: wall_hit = (cyi == 0)          || h_walls[h_idx_u];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Direction used by this step and the resulting one-pixel move.
  // ---------------------------------------------------------------------------
  logic       rev_req;
  logic [1:0] mdir;
  logic [8:0] px_m, py_m;
  logic       lands;

`ifdef PLAYER_REVERSE_EN
  assign rev_req = (dir_s == (dir ^ 2'b10));
`else
  assign rev_req = 1'b0;
`endif

  always_comb begin
    mdir = dir;
    if (state == ALIGNED || rev_req) mdir = dir_s;
    px_m = pos_x;
    py_m = pos_y;
    case (mdir)
      2'd0:    px_m = pos_x + 9'd1;
      2'd1:    py_m = pos_y + 9'd1;
      2'd2:    px_m = pos_x - 9'd1;
      default: py_m = pos_y - 9'd1;
    endcase
    // only the moving axis can leave alignment, so only it is tested
    lands = mdir[0] ? (py_m[CELL_BITS-1:0] == '0) : (px_m[CELL_BITS-1:0] == '0);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ALIGNED;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (step) begin
      case (state)
        ALIGNED: if (!wall_hit) state_nxt = MOVE;
        MOVE:    if (lands)     state_nxt = ALIGNED;
        default: state_nxt = ALIGNED;
      endcase
    end
  end

  // FSM: outputs / datapath next values
  always_comb begin
    pos_x_nxt   = pos_x;
    pos_y_nxt   = pos_y;
    dir_nxt     = dir;
    blocked_nxt = blocked;
    entered_nxt = 1'b0;     // pulse: cleared on every edge it is not set
    if (step) begin
      case (state)
        ALIGNED: begin
          dir_nxt = dir_s;
          if (wall_hit) begin
            blocked_nxt = 1'b1;
          end else begin
            pos_x_nxt   = px_m;
            pos_y_nxt   = py_m;
            blocked_nxt = 1'b0;
          end
        end
        MOVE: begin
          pos_x_nxt   = px_m;
          pos_y_nxt   = py_m;
          dir_nxt     = mdir;
          entered_nxt = lands;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x        <= '0;
      pos_y        <= '0;
      dir          <= '0;
      blocked      <= 1'b0;
      cell_entered <= 1'b0;
    end else begin
      pos_x        <= pos_x_nxt;
      pos_y        <= pos_y_nxt;
      dir          <= dir_nxt;
      blocked      <= blocked_nxt;
      cell_entered <= entered_nxt;
    end
  end

endmodule

// File: tb/tb_player_motion.sv
module tb_player_motion;

  localparam int GRID_W = 10;
  localparam int GRID_H = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        button_1 = 1'b0, button_2 = 1'b0, step = 1'b0;
  logic [GRID_W*(GRID_H+1)-1:0] h_walls = '0;
  logic [(GRID_W+1)*GRID_H-1:0] v_walls = '0;
  logic [8:0]  pos_x, pos_y;
  logic [3:0]  cell_x, cell_y;
  logic        moving, blocked, cell_entered;

  int errs   = 0;
  int checks = 0;

  player_motion #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(5)) dut (
    .clk(clk), .rst(rst), .button_1(button_1), .button_2(button_2),
    .step(step), .h_walls(h_walls), .v_walls(v_walls),
    .pos_x(pos_x), .pos_y(pos_y), .cell_x(cell_x), .cell_y(cell_y),
    .moving(moving), .blocked(blocked), .cell_entered(cell_entered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // step held high for n consecutive rising edges; returns at a falling edge
  task automatic steps(input int n);
    @(negedge clk); step = 1'b1;
    repeat (n) @(negedge clk);
    step = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // buttons take two edges to pass the synchroniser
  task automatic set_dir(input logic [1:0] d);
    {button_1, button_2} = d;
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    idle(3);
  endtask

  initial begin
    // ---- reset state
    idle(2);
    chk("rst_pos_x", int'(pos_x), 0);
    chk("rst_pos_y", int'(pos_y), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_blocked", int'(blocked), 0);
    chk("rst_entered", int'(cell_entered), 0);
    @(negedge clk); rst = 1'b1;
    idle(3);

    // ---- 32 back-to-back steps along +x
    steps(1);
    chk("x1_pos_x", int'(pos_x), 1);
    chk("x1_moving", int'(moving), 1);
    chk("x1_entered", int'(cell_entered), 0);
    steps(30);
    chk("x31_pos_x", int'(pos_x), 31);
    chk("x31_entered", int'(cell_entered), 0);
    steps(1);
    chk("x32_pos_x", int'(pos_x), 32);
    chk("x32_pos_y", int'(pos_y), 0);
    chk("x32_moving", int'(moving), 0);
    chk("x32_entered", int'(cell_entered), 1);
    chk("x32_cell_x", int'(cell_x), 1);
    idle(1);
    chk("x32_entered_drop", int'(cell_entered), 0);
    chk("x32_hold", int'(pos_x), 32);

    // ---- -x at left border refused, then +y accepted
    do_reset();
    set_dir(2'b10);
    steps(1);
    chk("bl_pos_x", int'(pos_x), 0);
    chk("bl_pos_y", int'(pos_y), 0);
    chk("bl_blocked", int'(blocked), 1);
    chk("bl_moving", int'(moving), 0);
    set_dir(2'b01);
    steps(1);
    chk("py_pos_y", int'(pos_y), 1);
    chk("py_blocked", int'(blocked), 0);
    chk("py_moving", int'(moving), 1);
    steps(31);
    chk("py_cell_y", int'(cell_y), 1);
    chk("py_entered", int'(cell_entered), 1);

    // ---- -y at top border refused
    do_reset();
    set_dir(2'b11);
    steps(1);
    chk("ty_pos_y", int'(pos_y), 0);
    chk("ty_blocked", int'(blocked), 1);

    // ---- wall on right edge of cell (0,0)
    do_reset();
    v_walls[1] = 1'b1;
    set_dir(2'b00);
    steps(1);
    chk("vw_pos_x", int'(pos_x), 0);
    chk("vw_blocked", int'(blocked), 1);
    chk("vw_moving", int'(moving), 0);
    v_walls = '0;
    // left edge of (0,0) is irrelevant to a +x move
    v_walls[0] = 1'b1;
    steps(1);
    chk("vl_pos_x", int'(pos_x), 1);
    chk("vl_blocked", int'(blocked), 0);
    v_walls = '0;

    // ---- wall on bottom edge of cell (0,0): h_walls[1*GRID_W+0]
    do_reset();
    h_walls[10] = 1'b1;
    set_dir(2'b01);
    steps(1);
    chk("hw_pos_y", int'(pos_y), 0);
    chk("hw_blocked", int'(blocked), 1);
    h_walls = '0;

    // ---- buttons and walls ignored mid-move
    do_reset();
    set_dir(2'b00);
    steps(10);
    v_walls = '1;
    set_dir(2'b01);
    steps(22);
    chk("ig_pos_x", int'(pos_x), 32);
    chk("ig_pos_y", int'(pos_y), 0);
    chk("ig_entered", int'(cell_entered), 1);
    steps(1);
    chk("ig_next_y", int'(pos_y), 1);
    chk("ig_next_x", int'(pos_x), 32);
    v_walls = '0;

    // ---- asynchronous reset mid-move
    do_reset();
    set_dir(2'b00);
    steps(17);
    chk("ar_pre", int'(pos_x), 17);
    #1 rst = 1'b0;
    #1;
    chk("ar_pos_x", int'(pos_x), 0);
    chk("ar_moving", int'(moving), 0);
    @(negedge clk); rst = 1'b1;
    idle(3);

    // ---- reverse request mid-move
    do_reset();
    set_dir(2'b00);
    steps(10);
    set_dir(2'b10);
    steps(1);
`ifdef PLAYER_REVERSE_EN
    chk("rv_pos_x", int'(pos_x), 9);
    steps(9);
    chk("rv_home", int'(pos_x), 0);
    chk("rv_entered", int'(cell_entered), 1);
    chk("rv_moving", int'(moving), 0);
`else
    chk("rv_pos_x", int'(pos_x), 11);
    chk("rv_moving", int'(moving), 1);
    steps(21);
    chk("rv_end", int'(pos_x), 32);
    chk("rv_entered", int'(cell_entered), 1);
`endif

    // ---- right border: cell 9 cannot move +x even with no wall bits
    do_reset();
    set_dir(2'b00);
    steps(9 * 32);
    chk("rb_pos_x", int'(pos_x), 288);
    chk("rb_cell_x", int'(cell_x), 9);
    steps(1);
    chk("rb_hold", int'(pos_x), 288);
    chk("rb_blocked", int'(blocked), 1);
    chk("rb_moving", int'(moving), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
